// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array feeder: array mode codes and the
// feeder state encoding.
package sa_pkg;

  localparam logic [1:0] MODE_IDLE    = 2'b00;
  localparam logic [1:0] MODE_LOAD    = 2'b01;
  localparam logic [1:0] MODE_COMPUTE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } feeder_state_t;

endpackage

// File: rtl/sa_skew_line.sv
// Enable-gated delay line of DEPTH stages used to skew one activation lane.
// DEPTH=0 degenerates to a plain wire.
module sa_skew_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_s;
      assign unused_s = ^{clk, rst_n, en};
      assign dout = din;
    end else begin : g_pipe
      logic [DATA_WIDTH-1:0] stage_r [DEPTH];

      // Shift register advancing only on array-advance cycles
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage_r[i] <= '0;
        end else if (en) begin
          stage_r[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
        end
      end

      assign dout = stage_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sa_feeder.sv
// Initiator for a weight-stationary PE array: weight load, skewed activation
// streaming and zero drain. Optional weight reuse under SA_FEEDER_WEIGHT_REUSE_EN.
module sa_feeder
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int VEC_CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       reuse_w,
  input  logic [VEC_CNT_W-1:0]       num_vecs,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [COLS*DATA_WIDTH-1:0] w_data,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] a_data,
  output logic [1:0]                 mode_ctrl,
  output logic [COLS*DATA_WIDTH-1:0] weight_out,
  output logic [COLS-1:0]            weight_rdy_out,
  output logic [ROWS*DATA_WIDTH-1:0] data_out,
  output logic                       busy,
  output logic                       done
);

  localparam int BEAT_W  = $clog2(ROWS + 1);
  localparam int DRAIN_W = $clog2(ROWS + COLS);
  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(ROWS - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(ROWS + COLS - 2);

  feeder_state_t              state_r, state_s;
  logic [BEAT_W-1:0]          beat_cnt_r;
  logic [VEC_CNT_W-1:0]       vec_cnt_r;
  logic [VEC_CNT_W-1:0]       num_vecs_r;
  logic [DRAIN_W-1:0]         drain_cnt_r;
  logic                       w_fire_s, a_fire_s, reuse_ok_s;
  logic [ROWS*DATA_WIDTH-1:0] lane_in_s;

`ifdef SA_FEEDER_WEIGHT_REUSE_EN
  logic w_loaded_r;

  // Remembers that a complete weight set sits in the array since reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_loaded_r <= 1'b0;
    end else if (w_fire_s && (beat_cnt_r == LAST_BEAT)) begin
      w_loaded_r <= 1'b1;
    end
  end

  assign reuse_ok_s = reuse_w & w_loaded_r;
`else
  logic unused_reuse_s;
  assign unused_reuse_s = reuse_w;
  assign reuse_ok_s     = 1'b0;
`endif

  // Next-state and handshake/array-control decode
  always_comb begin
    state_s        = state_r;
    mode_ctrl      = MODE_IDLE;
    w_ready        = 1'b0;
    a_ready        = 1'b0;
    weight_out     = '0;
    weight_rdy_out = '0;
    busy           = 1'b1;
    done           = 1'b0;
    w_fire_s       = 1'b0;
    a_fire_s       = 1'b0;
    lane_in_s      = '0;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (reuse_ok_s) state_s = (num_vecs == '0) ? ST_DONE : ST_STREAM;
          else            state_s = ST_LOAD_W;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD_W: begin
        w_ready  = 1'b1;
        w_fire_s = w_valid;
        if (w_fire_s) begin
          mode_ctrl      = MODE_LOAD;
          weight_out     = w_data;
          weight_rdy_out = '1;
          if (beat_cnt_r == LAST_BEAT) state_s = (num_vecs_r == '0) ? ST_DONE : ST_STREAM;
          else                         state_s = ST_LOAD_W;
        end else begin
          state_s = ST_LOAD_W;
        end
      end
      ST_STREAM: begin
        a_ready   = 1'b1;
        a_fire_s  = a_valid;
        lane_in_s = a_data;
        if (a_fire_s) begin
          mode_ctrl = MODE_COMPUTE;
          if (vec_cnt_r == (num_vecs_r - VEC_CNT_W'(1))) state_s = ST_DRAIN;
          else                                           state_s = ST_STREAM;
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        mode_ctrl = MODE_COMPUTE;
        if (drain_cnt_r == LAST_DRAIN) state_s = ST_DONE;
        else                           state_s = ST_DRAIN;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register, tile length latch and beat/vector/drain counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      num_vecs_r  <= '0;
      beat_cnt_r  <= '0;
      vec_cnt_r   <= '0;
      drain_cnt_r <= '0;
    end else begin
      state_r <= state_s;
      if ((state_r == ST_IDLE) && start) begin
        num_vecs_r  <= num_vecs;
        beat_cnt_r  <= '0;
        vec_cnt_r   <= '0;
        drain_cnt_r <= '0;
      end else begin
        if (w_fire_s)              beat_cnt_r  <= beat_cnt_r + BEAT_W'(1);
        if (a_fire_s)              vec_cnt_r   <= vec_cnt_r + VEC_CNT_W'(1);
        if (state_r == ST_DRAIN)   drain_cnt_r <= drain_cnt_r + DRAIN_W'(1);
      end
    end
  end

  // Lane r is delayed by r advancing cycles to form the input wavefront
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    sa_skew_line #(
      .DEPTH      (r),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (mode_ctrl[1]),
      .din   (lane_in_s[r*DATA_WIDTH +: DATA_WIDTH]),
      .dout  (data_out[r*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule
